// File: rtl/nn_pkg.sv
// Shared types and helpers for the neural-network accumulator stage.
// Ciphertext coefficients are two independent 18-bit lanes packed into 36 bits.
package nn_pkg;

    localparam int LANE_W         = 18;
    localparam int CT_W           = 36;
    localparam int IDX_K_W        = 10;
    localparam int IDX_N_W        = 10;
    localparam int IDX_W_W        = 6;
    localparam int K_VAL_DEF      = 501;
    localparam int DEPTH_DEF      = 100;
    localparam int OUT_NODES_DEF  = 10;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef logic [CT_W-1:0] ct_t;
    typedef logic [$clog2(OUT_NODES_DEF*K_VAL_DEF)-1:0] acc_addr_t;

    typedef struct packed {
        ct_t                val;
        logic [IDX_K_W-1:0] k;
        logic [IDX_W_W-1:0] w;
    } acc_entry_t;

    // Each lane wraps modulo 2^18; no carry crosses from bit 17 into bit 18.
    function automatic ct_t lane_add(ct_t a, ct_t b);
        logic [LANE_W-1:0] hi;
        logic [LANE_W-1:0] lo;
        hi = a[CT_W-1:LANE_W] + b[CT_W-1:LANE_W];
        lo = a[LANE_W-1:0] + b[LANE_W-1:0];
        return {hi, lo};
    endfunction

endpackage

// File: rtl/nn_acc_bram.sv
// Simple dual-port accumulator RAM: one write port, one registered read port.
// A read and write to the same address on one edge returns the old contents.
module nn_acc_bram import nn_pkg::*; #(
    parameter int DATA_W = CT_W,
    parameter int WORDS  = OUT_NODES_DEF * K_VAL_DEF,
    parameter int ADDR_W = $clog2(WORDS)
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [0:WORDS-1];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/nn_accumulator.sv
// Per-(w,k) accumulator over DEPTH inputs: accept -> RAM read -> add/write/push,
// with finished coefficients streamed out through a small FIFO with registered head.
module nn_accumulator import nn_pkg::*; #(
    parameter int K_VAL      = K_VAL_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int OUT_NODES  = OUT_NODES_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               sum_valid,
    output logic               sum_ready,
    input  logic [CT_W-1:0]    sum_in,
    input  logic [IDX_K_W-1:0] sum_idx_k,
    input  logic [IDX_N_W-1:0] sum_idx_N,
    input  logic [IDX_W_W-1:0] sum_idx_w,
    output logic               acc_valid,
    input  logic               acc_ready,
    output logic [CT_W-1:0]    acc_out,
    output logic [IDX_K_W-1:0] acc_idx_k,
    output logic [IDX_W_W-1:0] acc_idx_w,
    output logic               idx_err
);

    localparam int WORDS  = OUT_NODES * K_VAL;
    localparam int ADDR_W = $clog2(WORDS);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int OCC_W  = CNT_W + 1;

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // payloads are sampled only then, and acc_* hold while acc_valid && !acc_ready.
    logic              w_xfer;
    logic              w_in_range;
    logic [ADDR_W-1:0] w_addr;
    logic [CT_W-1:0]   w_rd_data;
    logic [CT_W-1:0]   w_old;
    logic [CT_W-1:0]   w_new;
    logic              w_push;
    logic              w_load;
    logic [OCC_W-1:0]  w_occ;

    logic               r_run;
    logic               r_idx_err;
    logic               r_s1_valid, r_s1_n0, r_s1_last;
    logic [ADDR_W-1:0]  r_s1_addr;
    logic [CT_W-1:0]    r_s1_sum;
    logic [IDX_K_W-1:0] r_s1_k;
    logic [IDX_W_W-1:0] r_s1_w;
    logic               r_s2_valid, r_s2_n0, r_s2_last, r_s2_fwd;
    logic [ADDR_W-1:0]  r_s2_addr;
    logic [CT_W-1:0]    r_s2_sum;
    logic [IDX_K_W-1:0] r_s2_k;
    logic [IDX_W_W-1:0] r_s2_w;
    logic [CT_W-1:0]    r_fwd_data;

    acc_entry_t        r_fifo [0:FIFO_DEPTH-1];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_acc_valid;
    acc_entry_t        r_acc_entry;

    assign w_xfer     = sum_valid && sum_ready;
    assign w_in_range = (32'(sum_idx_k) < K_VAL) && (32'(sum_idx_w) < OUT_NODES)
                        && (32'(sum_idx_N) < DEPTH);
    assign w_addr     = ADDR_W'(32'(sum_idx_w) * K_VAL + 32'(sum_idx_k));

    nn_acc_bram #(.DATA_W(CT_W), .WORDS(WORDS), .ADDR_W(ADDR_W)) u_bram (
        .i_clk     (clk_in),
        .i_wr_en   (r_s2_valid),
        .i_wr_addr (r_s2_addr),
        .i_wr_data (w_new),
        .i_rd_addr (r_s1_addr),
        .o_rd_data (w_rd_data)
    );

    // The RAM read for an S2 item lands on the same edge as the previous item's
    // write, so only that one write can be missed; earlier writes are already in RAM.
    assign w_old  = r_s2_fwd ? r_fwd_data : w_rd_data;
    assign w_new  = lane_add(r_s2_n0 ? '0 : w_old, r_s2_sum);
    assign w_push = r_s2_valid && r_s2_last;
    assign w_load = (r_cnt != '0) && (!r_acc_valid || acc_ready);

    assign w_occ = OCC_W'(r_cnt) + OCC_W'(r_acc_valid)
                 + OCC_W'(r_s1_valid && r_s1_last) + OCC_W'(r_s2_valid && r_s2_last);
    assign sum_ready = r_run && (w_occ <= OCC_W'(FIFO_DEPTH - 1));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_run      <= 1'b0;
            r_idx_err  <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_n0    <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_addr  <= '0;
            r_s1_sum   <= '0;
            r_s1_k     <= '0;
            r_s1_w     <= '0;
            r_s2_valid <= 1'b0;
            r_s2_n0    <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_fwd   <= 1'b0;
            r_s2_addr  <= '0;
            r_s2_sum   <= '0;
            r_s2_k     <= '0;
            r_s2_w     <= '0;
            r_fwd_data <= '0;
        end else begin
            r_run      <= 1'b1;
            r_s1_valid <= w_xfer && w_in_range;
            if (w_xfer) begin
                r_s1_addr <= w_addr;
                r_s1_sum  <= sum_in;
                r_s1_n0   <= (sum_idx_N == '0);
                r_s1_last <= (32'(sum_idx_N) == DEPTH - 1);
                r_s1_k    <= sum_idx_k;
                r_s1_w    <= sum_idx_w;
            end
            if (w_xfer && !w_in_range) begin
                r_idx_err <= 1'b1;
            end
            r_s2_valid <= r_s1_valid;
            r_s2_n0    <= r_s1_n0;
            r_s2_last  <= r_s1_last;
            r_s2_addr  <= r_s1_addr;
            r_s2_sum   <= r_s1_sum;
            r_s2_k     <= r_s1_k;
            r_s2_w     <= r_s1_w;
            r_s2_fwd   <= r_s2_valid && (r_s2_addr == r_s1_addr);
            r_fwd_data <= w_new;
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {w_new, r_s2_k, r_s2_w};
        end
    end

    // acc_* is a prefetch register in front of the FIFO memory; it counts as one entry.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
            r_acc_valid <= 1'b0;
            r_acc_entry <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_load) begin
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                r_acc_entry <= r_fifo[r_rd_ptr];
                r_acc_valid <= 1'b1;
            end else if (acc_ready) begin
                r_acc_valid <= 1'b0;
            end
            r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_load);
        end
    end

    assign acc_valid = r_acc_valid;
    assign acc_out   = r_acc_entry.val;
    assign acc_idx_k = r_acc_entry.k;
    assign acc_idx_w = r_acc_entry.w;
    assign idx_err   = r_idx_err;

endmodule

// File: tb/tb_nn_accumulator.sv
// Self-checking bench for nn_accumulator with a sequential golden model and an
// expected-output queue; DEPTH is reduced so a full sweep of every entry stays short.
module tb_nn_accumulator;

    localparam int K_VAL      = 501;
    localparam int DEPTH      = 4;
    localparam int OUT_NODES  = 10;
    localparam int FIFO_DEPTH = 4;
    localparam int WORDS      = K_VAL * OUT_NODES;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sum_valid = 1'b0;
    logic        sum_ready;
    logic [35:0] sum_in = '0;
    logic [9:0]  sum_idx_k = '0;
    logic [9:0]  sum_idx_N = '0;
    logic [5:0]  sum_idx_w = '0;
    logic        acc_valid;
    logic        acc_ready = 1'b0;
    logic [35:0] acc_out;
    logic [9:0]  acc_idx_k;
    logic [5:0]  acc_idx_w;
    logic        idx_err;

    int n_checks = 0;
    int n_pass   = 0;
    int n_pops   = 0;
    int cyc      = 0;
    logic rand_ready = 1'b0;

    logic [35:0] model_mem [0:WORDS-1];
    logic [51:0] exp_q [$];

    nn_accumulator #(
        .K_VAL(K_VAL), .DEPTH(DEPTH), .OUT_NODES(OUT_NODES), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_in    (clk),
        .rst_in    (rst),
        .sum_valid (sum_valid),
        .sum_ready (sum_ready),
        .sum_in    (sum_in),
        .sum_idx_k (sum_idx_k),
        .sum_idx_N (sum_idx_N),
        .sum_idx_w (sum_idx_w),
        .acc_valid (acc_valid),
        .acc_ready (acc_ready),
        .acc_out   (acc_out),
        .acc_idx_k (acc_idx_k),
        .acc_idx_w (acc_idx_w),
        .idx_err   (idx_err)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
        n_checks++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            if (rand_ready) acc_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // golden model: lanes are plain integers reduced modulo 2^18
    function automatic logic [35:0] model_fold(input logic [35:0] old, input int n,
                                               input logic [35:0] s);
        int unsigned hi, lo;
        hi = 0;
        lo = 0;
        if (n != 0) begin
            hi = 32'(old[35:18]);
            lo = 32'(old[17:0]);
        end
        hi = (hi + 32'(s[35:18])) % 262144;
        lo = (lo + 32'(s[17:0])) % 262144;
        return {hi[17:0], lo[17:0]};
    endfunction

    function automatic logic [35:0] rand_ct();
        logic [17:0] h, l;
        h = 18'($urandom_range(0, 262143));
        l = 18'($urandom_range(0, 262143));
        return {h, l};
    endfunction

    task automatic model_accept(input int k, input int n, input int w, input logic [35:0] s);
        int a;
        if (k >= K_VAL || w >= OUT_NODES || n >= DEPTH) return;
        a = w * K_VAL + k;
        model_mem[a] = model_fold(model_mem[a], n, s);
        if (n == DEPTH - 1) exp_q.push_back({model_mem[a], 10'(k), 6'(w)});
    endtask

    // driver: called a little after a rising edge, returns 1 ns after the accepting edge
    task automatic send(input int k, input int n, input int w, input logic [35:0] s);
        int budget;
        sum_idx_k = 10'(k);
        sum_idx_N = 10'(n);
        sum_idx_w = 6'(w);
        sum_in    = s;
        sum_valid = 1'b1;
        budget = 0;
        @(negedge clk);
        while (!sum_ready && budget < 1000) begin
            @(negedge clk);
            budget++;
        end
        if (!sum_ready) begin
            n_checks++;
            $display("FAIL send_timeout: sum_ready=%b after %0d cycles, required 1", sum_ready, budget);
            sum_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_accept(k, n, w, s);
        #1 sum_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int b;
        b = 0;
        while (exp_q.size() != 0 && b < 3000) begin
            @(posedge clk);
            b++;
        end
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL %s_drain: %0d outputs missing, required 0", name, exp_q.size());
        else n_pass++;
    endtask

    // scoreboard: every output handshake is matched against the expected queue
    logic        hold = 1'b0;
    logic [51:0] hold_data;
    always @(negedge clk) begin
        logic [51:0] got, exp;
        if (rst) begin
            hold = 1'b0;
        end else begin
            got = {acc_out, acc_idx_k, acc_idx_w};
            if (hold) begin
                n_checks++;
                if (!acc_valid || got !== hold_data)
                    $display("FAIL hold_stable: valid=%b data=%h, required valid=1 data=%h", acc_valid, got, hold_data);
                else n_pass++;
            end
            if (acc_valid && acc_ready) begin
                n_checks++;
                n_pops++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_output: got %h, required no output", got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) $display("FAIL scoreboard: got %h, required %h", got, exp);
                    else n_pass++;
                end
            end
            hold = acc_valid && !acc_ready;
            hold_data = got;
        end
    end

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (sum_ready !== 1'b0) $display("FAIL rst_sum_ready: %b, required 0", sum_ready); else n_pass++;
        n_checks++; if (acc_valid !== 1'b0) $display("FAIL rst_acc_valid: %b, required 0", acc_valid); else n_pass++;
        n_checks++; if (acc_out !== 36'd0) $display("FAIL rst_acc_out: %h, required 0", acc_out); else n_pass++;
        n_checks++; if (acc_idx_k !== 10'd0 || acc_idx_w !== 6'd0)
            $display("FAIL rst_acc_idx: k=%0d w=%0d, required 0 0", acc_idx_k, acc_idx_w); else n_pass++;
        n_checks++; if (idx_err !== 1'b0) $display("FAIL rst_idx_err: %b, required 0", idx_err); else n_pass++;
        @(posedge clk);
        #1 rst = 1'b0;
        acc_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (sum_ready !== 1'b1) $display("FAIL rst_release_ready: %b, required 1", sum_ready); else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_fold();
        for (int n = 0; n < DEPTH; n++) send(0, n, 0, {18'd1, 18'd2});
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (acc_valid !== 1'b0) $display("FAIL basic_early: acc_valid=%b 2 cycles after accept, required 0", acc_valid); else n_pass++;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (acc_valid !== 1'b1) $display("FAIL basic_latency: acc_valid=%b 3 cycles after accept, required 1", acc_valid); else n_pass++;
        n_checks++; if (acc_out !== {18'd4, 18'd8} || acc_idx_k !== 10'd0 || acc_idx_w !== 6'd0)
            $display("FAIL basic_value: %h k=%0d w=%0d, required %h k=0 w=0", acc_out, acc_idx_k, acc_idx_w, {18'd4, 18'd8});
        else n_pass++;
        @(posedge clk);
        #1;
        drain("basic");
    endtask

    task automatic wait_and_check(input string name, input logic [35:0] want, input int k, input int w);
        int b;
        b = 0;
        @(negedge clk);
        while (!acc_valid && b < 20) begin
            @(negedge clk);
            b++;
        end
        n_checks++;
        if (!acc_valid || acc_out !== want || acc_idx_k !== 10'(k) || acc_idx_w !== 6'(w))
            $display("FAIL %s: valid=%b out=%h k=%0d w=%0d, required out=%h k=%0d w=%0d",
                     name, acc_valid, acc_out, acc_idx_k, acc_idx_w, want, k, w);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_lane_wrap();
        send(1, 0, 2, {18'h3FFFF, 18'h3FFFF});
        for (int n = 1; n < DEPTH - 1; n++) send(1, n, 2, 36'd0);
        send(1, DEPTH - 1, 2, {18'd1, 18'd2});
        wait_and_check("lane_wrap", {18'd0, 18'd1}, 1, 2);
        drain("lane_wrap");
    endtask

    task automatic test_hazard();
        for (int pass = 0; pass < 2; pass++) begin
            for (int n = 0; n < DEPTH; n++) send(5, n, 9, {18'd0, 18'(n + 1)});
            wait_and_check(pass == 0 ? "hazard_first" : "hazard_stale", {18'd0, 18'd10}, 5, 9);
        end
        drain("hazard");
    endtask

    task automatic test_idx_err();
        int pops0;
        pops0 = n_pops;
        n_checks++; if (idx_err !== 1'b0) $display("FAIL err_before: idx_err=%b, required 0", idx_err); else n_pass++;
        send(K_VAL, DEPTH - 1, 0, rand_ct());
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (idx_err !== 1'b1) $display("FAIL err_k: idx_err=%b, required 1", idx_err); else n_pass++;
        send(0, DEPTH - 1, OUT_NODES, rand_ct());
        send(0, DEPTH, 0, rand_ct());
        repeat (6) @(posedge clk);
        #1;
        n_checks++; if (idx_err !== 1'b1) $display("FAIL err_sticky: idx_err=%b, required 1", idx_err); else n_pass++;
        n_checks++; if (n_pops != pops0) $display("FAIL err_no_output: %0d outputs, required 0", n_pops - pops0); else n_pass++;
        // address 0 must still hold the earlier completed value; continuing from N=1 exposes it
        for (int n = 1; n < DEPTH; n++) send(0, n, 0, rand_ct());
        for (int n = 0; n < DEPTH; n++) send(7, n, 8, rand_ct());
        drain("idx_err");
    endtask

    task automatic test_backpressure();
        int acc_cnt, pops0;
        for (int i = 0; i < 8; i++)
            for (int n = 0; n < DEPTH - 1; n++) send(10 + i, n, 3, rand_ct());
        repeat (4) @(posedge clk);
        #1 acc_ready = 1'b0;
        pops0 = n_pops;
        acc_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (acc_cnt < 8) begin
                sum_idx_k = 10'(10 + acc_cnt);
                sum_idx_N = 10'(DEPTH - 1);
                sum_idx_w = 6'd3;
                sum_in    = rand_ct();
                sum_valid = 1'b1;
            end
            @(negedge clk);
            if (sum_valid && sum_ready) begin
                @(posedge clk);
                model_accept(10 + acc_cnt, DEPTH - 1, 3, sum_in);
                acc_cnt++;
            end else begin
                @(posedge clk);
            end
            #1 sum_valid = 1'b0;
        end
        n_checks++; if (acc_cnt != FIFO_DEPTH) $display("FAIL bp_accepted: %0d accepted, required %0d", acc_cnt, FIFO_DEPTH); else n_pass++;
        @(negedge clk);
        n_checks++; if (sum_ready !== 1'b0) $display("FAIL bp_ready: sum_ready=%b, required 0", sum_ready); else n_pass++;
        n_checks++; if (n_pops != pops0) $display("FAIL bp_no_pop: %0d pops, required 0", n_pops - pops0); else n_pass++;
        @(posedge clk);
        #1 acc_ready = 1'b1;
        for (int i = acc_cnt; i < 8; i++) send(10 + i, DEPTH - 1, 3, rand_ct());
        drain("backpressure");
        n_checks++; if (n_pops - pops0 != 8) $display("FAIL bp_count: %0d outputs, required 8", n_pops - pops0); else n_pass++;
    endtask

    task automatic test_reset_midflight();
        acc_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            for (int n = 0; n < DEPTH; n++) send(100 + i, n, 4, rand_ct());
        repeat (6) @(posedge clk);
        #1;
        n_checks++; if (acc_valid !== 1'b1) $display("FAIL mid_fifo_loaded: acc_valid=%b, required 1", acc_valid); else n_pass++;
        send(200, 0, 4, rand_ct());
        send(201, 0, 4, rand_ct());
        #2 rst = 1'b1;
        #1;
        n_checks++; if (acc_valid !== 1'b0) $display("FAIL mid_rst_valid: acc_valid=%b, required 0", acc_valid); else n_pass++;
        n_checks++; if (sum_ready !== 1'b0) $display("FAIL mid_rst_ready: sum_ready=%b, required 0", sum_ready); else n_pass++;
        exp_q.delete();
        @(negedge clk);
        n_checks++; if (sum_ready !== 1'b0) $display("FAIL mid_rst_hold_ready: sum_ready=%b, required 0", sum_ready); else n_pass++;
        n_checks++; if (idx_err !== 1'b0) $display("FAIL mid_rst_idx_err: idx_err=%b, required 0", idx_err); else n_pass++;
        @(posedge clk);
        #1 rst = 1'b0;
        acc_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (sum_ready !== 1'b1) $display("FAIL mid_release_ready: sum_ready=%b, required 1", sum_ready); else n_pass++;
        n_checks++; if (acc_valid !== 1'b0) $display("FAIL mid_release_valid: acc_valid=%b, required 0", acc_valid); else n_pass++;
        @(posedge clk);
        #1;
        for (int n = 0; n < DEPTH; n++) send(200, n, 4, rand_ct());
        drain("reset_midflight");
    endtask

    task automatic test_random_hazards();
        int ak[6];
        int nn[6];
        int j;
        for (int i = 0; i < 6; i++) begin
            ak[i] = $urandom_range(0, K_VAL - 1);
            nn[i] = 0;
        end
        rand_ready = 1'b1;
        for (int t = 0; t < 400; t++) begin
            j = $urandom_range(0, 5);
            send(ak[j], nn[j], j, rand_ct());
            nn[j] = (nn[j] + 1) % DEPTH;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain("random");
        rand_ready = 1'b0;
        @(posedge clk);
        #2 acc_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_sweep();
        rand_ready = 1'b1;
        for (int n = 0; n < DEPTH; n++)
            for (int a = 0; a < WORDS; a++) send(a % K_VAL, n, a / K_VAL, rand_ct());
        drain("full_sweep");
        rand_ready = 1'b0;
        @(posedge clk);
        #2 acc_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic_fold();
        test_lane_wrap();
        test_hazard();
        test_idx_err();
        test_backpressure();
        test_reset_midflight();
        test_random_hazards();
        test_full_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
